// File: rtl/mult_8_8_pow_seq_pkg.sv
// ============================================================================
// Module : mult_8_8_pow_seq_pkg
// Brief  : State encoding shared by the power sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mult_8_8_pow_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mult_8_8.sv
// ============================================================================
// Module : mult_8_8
// Brief  : Combinational 8x8 multiplier, product truncated to the low 8 bits.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mult_8_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] out
);

    logic [15:0] w_full;

    assign w_full = a * b;
    assign out    = w_full[7:0];

endmodule

`default_nettype wire

// File: rtl/mult_8_8_pow_seq.sv
// ============================================================================
// Module : mult_8_8_pow_seq
// Brief  : Computes a * b^n mod 2^WIDTH, one shared multiply per cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mult_8_8_pow_seq
    import mult_8_8_pow_seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [EXP_WIDTH-1:0] n,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out
);

    state_t               r_state;
    state_t               w_next_state;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_base;
    logic [EXP_WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0]     w_prod;
    logic                 w_accept;
    logic                 w_last;

    mult_8_8 u_mult (
        .a   (r_acc),
        .b   (r_base),
        .out (w_prod)
    );

    // in_ready is masked by rst so no job is accepted in a reset cycle
    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign out       = r_acc;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == EXP_WIDTH'(1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = (n != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_base  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc  <= a;
                        r_base <= b;
                        r_cnt  <= n;
                    end
                end
                S_RUN: begin
                    r_acc <= w_prod;
                    r_cnt <= r_cnt - EXP_WIDTH'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_8_8_pow_seq.sv
// ============================================================================
// Module : tb_mult_8_8_pow_seq
// Brief  : Directed scoreboard bench for the power sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mult_8_8_pow_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] n;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;

    int         n_cmp;
    int         n_err;
    int         hs_cnt;
    logic [7:0] exp_q[$];

    mult_8_8_pow_seq #(.WIDTH(8), .EXP_WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .n         (n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every completed output handshake pops one expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_result", 1, 0);
            end else begin
                check("result", int'(out), int'(exp_q.pop_front()));
            end
        end
    end

    // Present a job and hold it until accepted; returns just after the accept edge.
    task automatic send(input logic [7:0] va, input logic [7:0] vb,
                        input logic [3:0] vn, input logic [7:0] vexp,
                        input bit push);
        int i;
        a = va; b = vb; n = vn; in_valid = 1'b1;
        for (i = 0; i < 200; i++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        if (i == 200) check("accept_timeout", 1, 0);
        if (push) exp_q.push_back(vexp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts negedges from the accept until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 60);
        if (!out_valid) check("valid_timeout", 1, 0);
    endtask

    initial begin
        int lat;
        int bad;
        int hs_before;
        n_cmp = 0; n_err = 0; hs_cnt = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; n = '0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out", int'(out), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", int'(in_ready), 1);

        // 2*3^3 = 54, four cycles to valid, ready again one cycle later
        send(8'd2, 8'd3, 4'd3, 8'd54, 1'b1);
        wait_valid(lat);
        check("lat_n3", lat, 4);
        check("busy_in_ready", int'(in_ready), 0);
        @(negedge clk);
        check("ready_after_n3", int'(in_ready), 1);

        // n = 0 passes a straight through
        send(8'd7, 8'd9, 4'd0, 8'd7, 1'b1);
        wait_valid(lat);
        check("lat_n0", lat, 1);
        @(negedge clk);

        // Wrap-around cases
        send(8'd3, 8'd5, 4'd4, 8'd83, 1'b1);
        wait_valid(lat);
        @(negedge clk);
        send(8'd16, 8'd16, 4'd2, 8'd0, 1'b1);
        wait_valid(lat);
        @(negedge clk);

        // Backpressure: result held stable while out_ready is low
        out_ready = 1'b0;
        send(8'd4, 8'd5, 4'd1, 8'd20, 1'b1);
        wait_valid(lat);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!out_valid || out != 8'd20 || in_ready) bad++;
            @(negedge clk);
        end
        check("backpressure_hold", bad, 0);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("released_valid", int'(out_valid), 0);

        // Reset in the middle of a long job: nothing may come out
        send(8'd2, 8'd3, 4'd8, 8'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out", int'(out), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        check("no_spurious", bad, 0);
        send(8'd1, 8'd2, 4'd2, 8'd4, 1'b1);
        wait_valid(lat);
        @(negedge clk);

        // Back-to-back: second job waits for the first handshake
        out_ready = 1'b0;
        send(8'd5, 8'd3, 4'd2, 8'd45, 1'b1);
        a = 8'd6; b = 8'd7; n = 4'd1; in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (in_ready) bad++;
        end
        check("b2b_blocked", bad, 0);
        hs_before = hs_cnt;
        out_ready = 1'b1;
        send(8'd6, 8'd7, 4'd1, 8'd42, 1'b1);
        check("b2b_order", hs_cnt, hs_before + 1);
        wait_valid(lat);
        @(negedge clk);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
